// File: rtl/ccastles_pkg.sv
// ccastles_pkg: address-range constants, decode helper and OUT1 bit indices for the Crystal Castles bus decoder
package ccastles_pkg;
   typedef struct packed {
      logic [15:0] base;
      logic [15:0] mask;
   } range_t;
   localparam range_t R_ROM0   = '{16'hA000, 16'hE000};
   localparam range_t R_ROM1   = '{16'hC000, 16'hE000};
   localparam range_t R_ROM2   = '{16'hE000, 16'hE000};
   localparam range_t R_SBUS   = '{16'h8000, 16'hE000};
   localparam range_t R_SRAM   = '{16'h8000, 16'hF000};
   localparam range_t R_NVRAM  = '{16'h9000, 16'hFC00};
   localparam range_t R_IN0    = '{16'h9400, 16'hFC00};
   localparam range_t R_CIO    = '{16'h9800, 16'hFC00};
   localparam range_t R_BITMD  = '{16'h0002, 16'hFFFF};
   localparam range_t R_XCOORD = '{16'h0000, 16'hFFFF};
   localparam range_t R_YCOORD = '{16'h0001, 16'hFFFF};
   localparam range_t R_UART   = '{16'h9C00, 16'hFF80};
   localparam range_t R_HSLD   = '{16'h9C80, 16'hFF80};
   localparam range_t R_VSLD   = '{16'h9D00, 16'hFF80};
   localparam range_t R_INTACK = '{16'h9D80, 16'hFF80};
   localparam range_t R_WDOG   = '{16'h9E00, 16'hFF80};
   localparam range_t R_OUT0   = '{16'h9E80, 16'hFF80};
   localparam range_t R_OUT1   = '{16'h9F00, 16'hFF80};
   localparam range_t R_CRAM   = '{16'h9F80, 16'hFFC0};
   localparam logic [2:0] OUT1_AX        = 3'd0;
   localparam logic [2:0] OUT1_AY        = 3'd1;
   localparam logic [2:0] OUT1_XINC      = 3'd2;
   localparam logic [2:0] OUT1_YINC      = 3'd3;
   localparam logic [2:0] OUT1_PLAYER2   = 3'd4;
   localparam logic [2:0] OUT1_SIRE      = 3'd5;
   localparam logic [2:0] OUT1_STARTLED1 = 3'd6;
   localparam logic [2:0] OUT1_BUF1BUF2  = 3'd7;
   function automatic logic hit(input logic [15:0] a, input range_t r);
      return (a & r.mask) == r.base;
   endfunction
endpackage

// File: rtl/ccastles_addr_latch8.sv
// ccastles_addr_latch8: 8-bit addressable latch (74LS259-style) with synchronous clear
// Ports: clk, reset (sync, active-high, wins over wen), wen (write bit sel), sel[2:0], d, q[7:0]
module ccastles_addr_latch8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       wen,
   input  logic [2:0] sel,
   input  logic       d,
   output logic [7:0] q
);
   always_ff @(posedge clk)
      if (reset) q <= '0;
      else if (wen) q[sel] <= d;
endmodule

// File: rtl/ccastles_bus_decoder.sv
// ccastles_bus_decoder: 6502 bus address decoder with level selects, registered write strobes and the OUT1 latch
// Ports: clk, reset (sync, active-high), ce2Hd (write qualifier), BA[15:0], BRWn, BD3 (OUT1 data);
//   level selects NRn/ROMxn/SBUSn/SRAMn/NVRAMn/IN0n/CIOn/BITMDn, UARTn,
//   one-clk write strobes XCOORDn..CRAMn, OUT1 latch bits AXn..BUF1BUF2n.
// Optional: define CCASTLES_UART_DECODE_EN to decode UARTn at 0x9C00-0x9C7F; otherwise UARTn is tied high.
module ccastles_bus_decoder
   import ccastles_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ce2Hd,
   input  logic [15:0] BA,
   input  logic        BRWn,
   input  logic        BD3,
   output logic        NRn,
   output logic        ROM0n,
   output logic        ROM1n,
   output logic        ROM2n,
   output logic        SBUSn,
   output logic        SRAMn,
   output logic        NVRAMn,
   output logic        IN0n,
   output logic        CIOn,
   output logic        BITMDn,
   output logic        XCOORDn,
   output logic        YCOORDn,
   output logic        UARTn,
   output logic        HSLDn,
   output logic        VSLDn,
   output logic        INTACKn,
   output logic        WDOGn,
   output logic        OUT0n,
   output logic        OUT1n,
   output logic        CRAMn,
   output logic        AXn,
   output logic        AYn,
   output logic        XINCn,
   output logic        YINCn,
   output logic        PLAYER2,
   output logic        SIREn,
   output logic        STARTLED1,
   output logic        BUF1BUF2n
);
   logic [8:0] hit_w;
   logic [8:0] strb_n;
   logic [7:0] q;
   assign NRn    = hit(BA, R_ROM0) | hit(BA, R_ROM1) | hit(BA, R_ROM2);
   assign ROM0n  = ~hit(BA, R_ROM0);
   assign ROM1n  = ~hit(BA, R_ROM1);
   assign ROM2n  = ~hit(BA, R_ROM2);
   assign SBUSn  = ~hit(BA, R_SBUS);
   assign SRAMn  = ~hit(BA, R_SRAM);
   assign NVRAMn = ~hit(BA, R_NVRAM);
   assign IN0n   = ~hit(BA, R_IN0);
   assign CIOn   = ~hit(BA, R_CIO);
   assign BITMDn = ~hit(BA, R_BITMD);
`ifdef CCASTLES_UART_DECODE_EN
   assign UARTn  = ~hit(BA, R_UART);
`else
   assign UARTn  = 1'b1;
`endif
   always_comb
      hit_w = {hit(BA, R_CRAM), hit(BA, R_OUT1), hit(BA, R_OUT0), hit(BA, R_WDOG), hit(BA, R_INTACK),
               hit(BA, R_VSLD), hit(BA, R_HSLD), hit(BA, R_YCOORD), hit(BA, R_XCOORD)};
   // Level-qualified, not edge-detected: every ce2Hd clock of a write produces a strobe.
   always_ff @(posedge clk)
      strb_n <= reset ? '1 : ~(hit_w & {9{ce2Hd & ~BRWn}});
   assign {CRAMn, OUT1n, OUT0n, WDOGn, INTACKn, VSLDn, HSLDn, YCOORDn, XCOORDn} = strb_n;
   // The latch writes during the strobe cycle; the bus holds BA/BD3 stable through it.
   ccastles_addr_latch8 u_out1 (
      .clk   (clk),
      .reset (reset),
      .wen   (~OUT1n),
      .sel   (BA[2:0]),
      .d     (BD3),
      .q     (q)
   );
   assign AXn       = q[OUT1_AX];
   assign AYn       = q[OUT1_AY];
   assign XINCn     = q[OUT1_XINC];
   assign YINCn     = q[OUT1_YINC];
   assign PLAYER2   = q[OUT1_PLAYER2];
   assign SIREn     = q[OUT1_SIRE];
   assign STARTLED1 = q[OUT1_STARTLED1];
   assign BUF1BUF2n = q[OUT1_BUF1BUF2];
endmodule

// File: tb/tb_ccastles_bus_decoder.sv
// tb_ccastles_bus_decoder: directed self-checking bench for ccastles_bus_decoder
module tb_ccastles_bus_decoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce2Hd = 1'b0;
   logic [15:0] BA = 16'h0000;
   logic        BRWn = 1'b1;
   logic        BD3 = 1'b0;
   logic NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn;
   logic XCOORDn, YCOORDn, UARTn, HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn;
   logic AXn, AYn, XINCn, YINCn, PLAYER2, SIREn, STARTLED1, BUF1BUF2n;
   int checks = 0;
   int failures = 0;
   always #50 clk = ~clk;
   ccastles_bus_decoder dut (
      .clk(clk), .reset(reset), .ce2Hd(ce2Hd), .BA(BA), .BRWn(BRWn), .BD3(BD3),
      .NRn(NRn), .ROM0n(ROM0n), .ROM1n(ROM1n), .ROM2n(ROM2n), .SBUSn(SBUSn), .SRAMn(SRAMn),
      .NVRAMn(NVRAMn), .IN0n(IN0n), .CIOn(CIOn), .BITMDn(BITMDn), .XCOORDn(XCOORDn),
      .YCOORDn(YCOORDn), .UARTn(UARTn), .HSLDn(HSLDn), .VSLDn(VSLDn), .INTACKn(INTACKn),
      .WDOGn(WDOGn), .OUT0n(OUT0n), .OUT1n(OUT1n), .CRAMn(CRAMn), .AXn(AXn), .AYn(AYn),
      .XINCn(XINCn), .YINCn(YINCn), .PLAYER2(PLAYER2), .SIREn(SIREn), .STARTLED1(STARTLED1),
      .BUF1BUF2n(BUF1BUF2n)
   );
   wire [9:0] lvl  = {NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn};
   wire [8:0] strb = {CRAMn, OUT1n, OUT0n, WDOGn, INTACKn, VSLDn, HSLDn, YCOORDn, XCOORDn};
   wire [7:0] lat  = {BUF1BUF2n, STARTLED1, SIREn, PLAYER2, YINCn, XINCn, AYn, AXn};
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // one ce2Hd write (or read) cycle: strobe pattern in the next clk, idle in the one after
   task automatic wr(input logic [15:0] a, input logic d, input logic rd, input logic [8:0] exp, input string tag);
      BA = a; BD3 = d; BRWn = rd; ce2Hd = 1'b1;
      tick;
      ce2Hd = 1'b0;
      chk({tag, "_strb"}, {7'd0, strb}, {7'd0, exp});
      tick;
      chk({tag, "_idle"}, {7'd0, strb}, 16'h01FF);
      BRWn = 1'b1;
   endtask
   logic [15:0] addrs [14] = '{16'h0000, 16'h0002, 16'h7FFF, 16'h8000, 16'h8FFF, 16'h9000, 16'h97FF,
                               16'h9800, 16'h9C01, 16'h9FFF, 16'hA000, 16'hC000, 16'hE000, 16'hFFFF};
   logic [9:0]  lvls  [14] = '{10'h1FF, 10'h1FE, 10'h1FF, 10'h1CF, 10'h1CF, 10'h1D7, 10'h1DB,
                               10'h1DD, 10'h1DF, 10'h1DF, 10'h2FF, 10'h37F, 10'h3BF, 10'h3BF};
   function automatic logic uart_exp(input logic [15:0] a);
`ifdef CCASTLES_UART_DECODE_EN
      return !(a >= 16'h9C00 && a <= 16'h9C7F);
`else
      return 1'b1;
`endif
   endfunction
   initial begin
      tick;
      tick;
      chk("rst_latch", {8'd0, lat}, 16'h0000);
      chk("rst_strb", {7'd0, strb}, 16'h01FF);
      reset = 1'b0;
      tick;
      for (int i = 0; i < 14; i++) begin
         BA = addrs[i]; BRWn = 1'b1; ce2Hd = 1'b1;
         #1;
         chk($sformatf("lvl_%h", addrs[i]), {6'd0, lvl}, {6'd0, lvls[i]});
         chk($sformatf("uart_%h", addrs[i]), {15'd0, UARTn}, {15'd0, uart_exp(addrs[i])});
         tick;
         chk($sformatf("rdstrb_%h", addrs[i]), {7'd0, strb}, 16'h01FF);
      end
      ce2Hd = 1'b0;
      BA = 16'h9C01; BRWn = 1'b0;
      #1;
      chk("uart_wr", {15'd0, UARTn}, {15'd0, uart_exp(16'h9C01)});
      BRWn = 1'b1;
      wr(16'h9D80, 1'b0, 1'b0, 9'h1EF, "intack");
      wr(16'h9D80, 1'b0, 1'b1, 9'h1FF, "intack_rd");
      wr(16'h9C80, 1'b0, 1'b0, 9'h1FB, "hsld");
      wr(16'h9D7F, 1'b0, 1'b0, 9'h1F7, "vsld");
      wr(16'h9E00, 1'b0, 1'b0, 9'h1DF, "wdog");
      wr(16'h9EFF, 1'b0, 1'b0, 9'h1BF, "out0");
      wr(16'h9FBF, 1'b0, 1'b0, 9'h0FF, "cram");
      wr(16'h9FC0, 1'b0, 1'b0, 9'h1FF, "gap9fc0");
      wr(16'h9C00, 1'b0, 1'b0, 9'h1FF, "gap9c00");
      wr(16'h0000, 1'b0, 1'b0, 9'h1FE, "xcoord");
      wr(16'h0001, 1'b0, 1'b0, 9'h1FD, "ycoord");
      chk("latch_pre", {8'd0, lat}, 16'h0000);
      wr(16'h9F04, 1'b1, 1'b0, 9'h17F, "out1_a");
      chk("latch_p2", {8'd0, lat}, 16'h0010);
      wr(16'h9F07, 1'b1, 1'b0, 9'h17F, "out1_b");
      chk("latch_buf", {8'd0, lat}, 16'h0090);
      wr(16'h9F04, 1'b0, 1'b0, 9'h17F, "out1_c");
      chk("latch_p2clr", {8'd0, lat}, 16'h0080);
      for (int b = 0; b < 8; b++) wr(16'h9F00 | 16'(b), 1'b1, 1'b0, 9'h17F, "out1_all");
      chk("latch_ff", {8'd0, lat}, 16'h00FF);
      BA = 16'h9D80; BRWn = 1'b0; ce2Hd = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("stuck_ce", {7'd0, strb}, 16'h01EF);
      end
      ce2Hd = 1'b0;
      reset = 1'b1;
      tick;
      chk("rst_latch2", {8'd0, lat}, 16'h0000);
      chk("rst_strb2", {7'd0, strb}, 16'h01FF);
      reset = 1'b0;
      BRWn = 1'b1;
      tick;
      BA = 16'h9F03; BD3 = 1'b1; BRWn = 1'b0; ce2Hd = 1'b1;
      tick;
      ce2Hd = 1'b0;
      chk("rst_race_strb", {7'd0, strb}, 16'h017F);
      reset = 1'b1;
      tick;
      chk("rst_race_latch", {8'd0, lat}, 16'h0000);
      chk("rst_race_strb2", {7'd0, strb}, 16'h01FF);
      ce2Hd = 1'b1;
      tick;
      chk("rst_blocks_wr", {7'd0, strb}, 16'h01FF);
      ce2Hd = 1'b0; reset = 1'b0; BRWn = 1'b1;
      tick;
      chk("rst_after", {8'd0, lat}, 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ccastles_bus_decoder.md
Name: ccastles_bus_decoder

Overview:
- CPU-bus address decoder for the Crystal Castles core; sits between the 6502 bus (BA, BRWn, BD) and all memory and I/O blocks.
- Produces level chip-selects for ROM, RAM, NVRAM, POKEY and inputs.
- Produces one-clock write strobes for scroll, watchdog, interrupt-ack, output latches, colour RAM and bitmap registers.
- Contains the OUT1 8-bit addressable latch that drives the auto-increment, player-flip and video-buffer controls.

Parameters:
- none

Ports:
- clk  in  1  system clock, 10 MHz
- reset  in  1  synchronous, active-high
- ce2Hd  in  1  one-clk enable, one clock after the CPU 2H phase; write-strobe qualifier
- BA  in  16  CPU address bus
- BRWn  in  1  1 = read, 0 = write
- BD3  in  1  CPU data bit 3; OUT1 latch data
- NRn  out  1  HIGH when BA in 0xA000-0xFFFF (ROM region)
- ROM0n, ROM1n, ROM2n  out  1 each  low for 0xA000-0xBFFF, 0xC000-0xDFFF, 0xE000-0xFFFF respectively
- SBUSn  out  1  low for 0x8000-0x9FFF
- SRAMn  out  1  low for 0x8000-0x8FFF
- NVRAMn  out  1  low for 0x9000-0x93FF
- IN0n  out  1  low for 0x9400-0x97FF
- CIOn  out  1  low for 0x9800-0x9BFF
- BITMDn  out  1  low for BA == 0x0002
- XCOORDn, YCOORDn  out  1 each  write strobes for 0x0000 and 0x0001
- UARTn  out  1  UART select (see Optional Feature)
- HSLDn, VSLDn, INTACKn, WDOGn  out  1 each  write strobes for 0x9C80-0x9CFF, 0x9D00-0x9D7F, 0x9D80-0x9DFF, 0x9E00-0x9E7F
- OUT0n  out  1  write strobe for 0x9E80-0x9EFF
- OUT1n  out  1  write strobe for 0x9F00-0x9F7F
- CRAMn  out  1  write strobe for 0x9F80-0x9FBF
- AXn, AYn, XINCn, YINCn, PLAYER2, SIREn, STARTLED1, BUF1BUF2n  out  1 each  OUT1 latch bits 0-7

Behaviour:
- Level selects (NRn, ROMxn, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn):
  - purely combinational from BA only;
  - independent of BRWn and reset.
- Write strobes (XCOORDn, YCOORDn, HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn):
  - registered, active-low;
  - go low for exactly one clk, in the cycle after a clk where ce2Hd=1, BRWn=0 and BA is in range;
  - high otherwise;
  - reads never strobe;
  - 0x9FC0-0x9FFF and 0x9C00-0x9C7F strobe nothing (feature off).
- OUT1 latch (74LS259 behaviour):
  - on a clk where OUT1n is low, bit[BA[2:0]] <= BD3; the other seven bits hold;
  - BA and BD3 must be held stable through the strobe cycle (6502 bus guarantees this);
  - new value is visible two clks after the qualifying ce2Hd.
- Reset:
  - all write strobes = 1;
  - all eight latch bits = 0;
  - reset wins over a simultaneous write.
- ce2Hd stuck high during one long write cycle yields one strobe per ce2Hd clk (no edge detection).

Optional Feature:
- Macro: CCASTLES_UART_DECODE_EN.
- When defined: UARTn is low, combinational, for BA 0x9C00-0x9C7F on read or write.
- When undefined: UARTn is tied 1.
- In both cases no other decode changes.

Decomposition:
- Shared package ccastles_pkg:
  - address range base/mask constants for every region above;
  - OUT1 bit-index constants (AX=0, AY=1, XINC=2, YINC=3, PLAYER2=4, SIRE=5, STARTLED1=6, BUF1BUF2=7).
- One sub-module ccastles_addr_latch8: 8-bit addressable latch with synchronous clear. Inputs clk, reset, wen, sel[2:0], d; output q[7:0].

Test Plan:
- Sweep BA 0x0000-0xFFFF with reads -> exactly one level select per region at the boundaries:
  - 0x8FFF SRAMn=0, 0x9000 NVRAMn=0;
  - 0x97FF IN0n=0, 0x9800 CIOn=0;
  - 0x9FFF nothing asserted; 0xA000 NRn=1 and ROM0n=0;
  - 0xE000 ROM2n=0; 0x0002 BITMDn=0.
- Write 0x9D80 with a ce2Hd pulse -> INTACKn low for exactly one clk, one clk later; the same access with BRWn=1 -> no strobe.
- Write BD3=1 to 0x9F04, then BD3=1 to 0x9F07 -> PLAYER2=1 and BUF1BUF2n=1, other latch bits stay 0.
- Write BD3=0 to 0x9F04 -> PLAYER2=0, BUF1BUF2n stays 1.
- Assert reset with latch=0xFF -> latch 0x00 and all strobes 1 next clk; reset coincident with an OUT1 write -> latch stays 0x00.
- Back-to-back writes to 0x0000 then 0x0001 on successive ce2Hd -> XCOORDn pulse then YCOORDn pulse, never overlapping.
- With CCASTLES_UART_DECODE_EN defined, read 0x9C01 -> UARTn=0; without it UARTn=1 at all addresses.
